// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port among NUM_REQ writeback
//   requesters and keeps a 32-entry busy scoreboard for decode.
//   - Per-requester valid/ready handshake; the arbiter grants at most one
//     requester per cycle. The write stage always accepts, so a grant is
//     never blocked.
//   - A granted transfer is registered onto rf_en/rf_rd/rf_data on the next
//     edge. rd==0 transfers are consumed but produce rf_en=0.
//   - Decode marks destinations busy at issue. A bit clears when the
//     matching write commits. A set and a clear of the same bit in the same
//     cycle leaves the bit set, because the new producer owns it.
//
// Configuration macro:
//   WB_ARB_ROUND_ROBIN_EN
//     defined   : round-robin priority, starting at (ptr+1) mod NUM_REQ.
//                 ptr takes the granted index on every transfer.
//     undefined : fixed priority (lowest index wins); no pointer state.
//
// Ports:
//   clk          in   1                  clock, all state on posedge
//   rst          in   1                  asynchronous active-low reset
//   req_valid    in   NUM_REQ            requester i has a write pending
//   req_rd       in   5*NUM_REQ          dest reg of requester i, [5i+4:5i]
//   req_data     in   WORD_SIZE*NUM_REQ  write data of requester i
//   req_ready    out  NUM_REQ            one-hot grant (transfer = valid&ready)
//   rf_en        out  1                  register file write enable (reg)
//   rf_rd        out  5                  register file destination (reg)
//   rf_data      out  WORD_SIZE          register file write data (reg)
//   issue_valid  in   1                  decode issues an instr writing issue_rd
//   issue_rd     in   5                  destination being issued
//   issue_ready  out  1                  issue accepted (no WAW conflict)
//   rs1, rs2     in   5 each             decode source operands
//   hazard       out  1                  busy[rs1] | busy[rs2]
//   busy         out  32                 scoreboard bit vector, bit 0 always 0
// ---------------------------------------------------------------------------

// Protocol checker: grant shape and the scoreboard's hard-wired zero bit.
module regfile_wb_arbiter_chk #(
  parameter int NUM_REQ = 3
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic [31:0]        busy
);

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(req_ready));

  a_grant_only_valid : assert property (@(posedge clk) disable iff (!rst)
    ((req_ready & ~req_valid) == {NUM_REQ{1'b0}}));

  a_grant_when_valid : assert property (@(posedge clk) disable iff (!rst)
    ((req_valid != {NUM_REQ{1'b0}}) |-> (req_ready != {NUM_REQ{1'b0}})));

  a_busy_r0_clear : assert property (@(posedge clk) disable iff (!rst)
    (busy[0] == 1'b0));

endmodule

module regfile_wb_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REQ   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [5*NUM_REQ-1:0]         req_rd,
  input  logic [WORD_SIZE*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rf_en,
  output logic [4:0]                   rf_rd,
  output logic [WORD_SIZE-1:0]         rf_data,
  input  logic                         issue_valid,
  input  logic [4:0]                   issue_rd,
  output logic                         issue_ready,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  output logic                         hazard,
  output logic [31:0]                  busy
);

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] sel_idx_s;
`endif

  logic [NUM_REQ-1:0]   grant_s;
  logic                 transfer_s;
  logic [4:0]           sel_rd_s;
  logic [WORD_SIZE-1:0] sel_data_s;

  logic                 rf_en_q;
  logic                 rf_en_d;
  logic [4:0]           rf_rd_q;
  logic [4:0]           rf_rd_d;
  logic [WORD_SIZE-1:0] rf_data_q;
  logic [WORD_SIZE-1:0] rf_data_d;

  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic                 commit_s;
  logic                 issue_ready_s;
  logic                 issue_fire_s;
  logic                 hazard_s;

  // Arbiter: scan candidates from lowest to highest priority.
  // The last valid candidate seen wins, so the highest-priority one prevails.
  always_comb begin
    int idx;
    grant_s    = {NUM_REQ{1'b0}};
    sel_rd_s   = 5'd0;
    sel_data_s = {WORD_SIZE{1'b0}};
`ifdef WB_ARB_ROUND_ROBIN_EN
    sel_idx_s  = {PTR_W{1'b0}};
`endif
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      // Candidate k of the rotation is (ptr + 1 + k) mod NUM_REQ. This
      // sum never reaches 2*NUM_REQ, so one subtraction is enough.
      idx = int'(ptr_q) + 1 + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
`else
      idx = k;
`endif
      if (req_valid[idx]) begin
        grant_s      = {NUM_REQ{1'b0}};
        grant_s[idx] = 1'b1;
        sel_rd_s     = req_rd[idx*5 +: 5];
        sel_data_s   = req_data[idx*WORD_SIZE +: WORD_SIZE];
`ifdef WB_ARB_ROUND_ROBIN_EN
        sel_idx_s    = PTR_W'(idx);
`endif
      end else begin
        grant_s = grant_s;
      end
    end
  end

  assign transfer_s = |grant_s;
  assign req_ready  = grant_s;

  // Write stage next state: load on transfer; rd==0 is consumed without a write.
  always_comb begin
    rf_en_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (transfer_s) begin
      rf_en_d   = (sel_rd_s != 5'd0);
      rf_rd_d   = sel_rd_s;
      rf_data_d = sel_data_s;
    end else begin
      rf_en_d   = 1'b0;
    end
  end

  // Scoreboard: a commit is a real write (rd != 0) that the register file
  // takes at the end of this cycle.
  assign commit_s = rf_en_q & (rf_rd_q != 5'd0);

  // A WAW issue is allowed when the pending write to that register retires
  // this cycle.
  assign issue_ready_s = ~busy_q[issue_rd]
                       | (commit_s & (rf_rd_q == issue_rd))
                       | (issue_rd == 5'd0);
  assign issue_fire_s  = issue_valid & issue_ready_s & (issue_rd != 5'd0);

  // Busy vector next state: clear on commit, then set on issue so the set wins.
  always_comb begin
    busy_d = busy_q;
    if (commit_s) begin
      busy_d[rf_rd_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_fire_s) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // The hazard check uses the current busy vector only. A commit-cycle clear
  // is not forwarded to it.
  assign hazard_s = (busy_q[rs1] & (rs1 != 5'd0)) | (busy_q[rs2] & (rs2 != 5'd0));

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Round-robin pointer next state: follow the granted index, hold when idle.
  always_comb begin
    if (transfer_s) begin
      ptr_d = sel_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Write-stage and scoreboard registers. Reset drops any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_en_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= {WORD_SIZE{1'b0}};
      busy_q    <= 32'd0;
    end else begin
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_en       = rf_en_q;
  assign rf_rd       = rf_rd_q;
  assign rf_data     = rf_data_q;
  assign busy        = busy_q;
  assign issue_ready = issue_ready_s;
  assign hazard      = hazard_s;

  regfile_wb_arbiter_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .busy      (busy_q)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int W = 32;
  localparam int N = 3;

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } wb_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [5*N-1:0] req_rd = '0;
  logic [W*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rf_en;
  logic [4:0]     rf_rd;
  logic [W-1:0]   rf_data;
  logic           issue_valid = 1'b0;
  logic [4:0]     issue_rd = 5'd0;
  logic           issue_ready;
  logic [4:0]     rs1 = 5'd0;
  logic [4:0]     rs2 = 5'd0;
  logic           hazard;
  logic [31:0]    busy;

  int  checks = 0;
  int  errors = 0;
  wb_t exp_q[$];
  wb_t mon_e;

  regfile_wb_arbiter #(.WORD_SIZE(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every real register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && rf_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_rd, rf_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_rd !== mon_e.rd || rf_data !== mon_e.data) begin
          errors++;
          $display("FAIL wb_scoreboard: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_data, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid   = '0;
    issue_valid = 1'b0;
    rst         = 1'b0;
    #3;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0 || busy !== 32'd0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got en=%b rd=%0d data=%h busy=%h ready=%b, required all zero",
               rf_en, rf_rd, rf_data, busy, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    // Put a write and a busy bit in flight, then reset asynchronously mid-cycle.
    issue_valid    = 1'b1;
    issue_rd       = 5'd4;
    req_valid      = 3'b001;
    req_rd[4:0]    = 5'd3;
    req_data[31:0] = 32'h0BAD_F00D;
    cycle();
    issue_valid = 1'b0;
    req_valid   = 3'b000;
    checks++;
    if (rf_en !== 1'b1 || busy !== 32'h0000_0010) begin
      errors++;
      $display("FAIL reset_prewrite: got en=%b busy=%h, required en=1 busy=00000010", rf_en, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rf_en !== 1'b0 || busy !== 32'd0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: got en=%b rd=%0d data=%h busy=%h, required all zero",
               rf_en, rf_rd, rf_data, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    req_valid      = 3'b001;
    req_rd[4:0]    = 5'd5;
    req_data[31:0] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL single_ready: got %b, required 001", req_ready);
    end
    exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    cycle();
    req_valid = 3'b000;
    checks++;
    if (rf_en !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: got en=%b rd=%0d data=%h, required en=1 rd=5 data=deadbeef",
               rf_en, rf_rd, rf_data);
    end
    cycle();
    checks++;
    if (rf_en !== 1'b0 || busy !== 32'd0) begin
      errors++;
      $display("FAIL single_after: got en=%b busy=%h, required en=0 busy=0", rf_en, busy);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    int           exp_i;
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_rd[i*5 +: 5]   = 5'(i + 1);
      req_data[i*W +: W] = 32'hC0DE_0000 + i;
    end
    for (int c = 0; c < 6; c++) begin
      #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_i = c % N;
`else
      exp_i = 0;
`endif
      exp_g = '0;
      exp_g[exp_i] = 1'b1;
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got %b, required %b", c, req_ready, exp_g);
      end
      exp_q.push_back('{rd: 5'(exp_i + 1), data: 32'hC0DE_0000 + exp_i});
      cycle();
    end
    req_valid = 3'b000;
    cycle();
  endtask

  task automatic test_back_to_back();
    req_valid = 3'b001;
    for (int i = 0; i < 4; i++) begin
      req_rd[4:0]    = 5'(10 + i);
      req_data[31:0] = 32'h5A5A_0000 + i;
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b, required 001", i, req_ready);
      end
      exp_q.push_back('{rd: 5'(10 + i), data: 32'h5A5A_0000 + i});
      cycle();
    end
    req_valid = 3'b000;
    cycle();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue_ready: got %b, required 1", issue_ready);
    end
    cycle();
    issue_valid = 1'b0;
    rs1 = 5'd7;
    rs2 = 5'd0;
    #1;
    checks++;
    if (busy !== 32'h0000_0080 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_set: got busy=%h hazard=%b, required busy=00000080 hazard=1", busy, hazard);
    end
    rs1 = 5'd3;
    rs2 = 5'd7;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL sb_hazard_rs2: got %b, required 1", hazard);
    end
    rs2 = 5'd0;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_no_hazard: got %b, required 0", hazard);
    end
    issue_valid = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL sb_waw_block: got %b, required 0", issue_ready);
    end
    issue_valid    = 1'b0;
    req_valid      = 3'b001;
    req_rd[4:0]    = 5'd7;
    req_data[31:0] = 32'h7777_0007;
    exp_q.push_back('{rd: 5'd7, data: 32'h7777_0007});
    cycle();
    req_valid = 3'b000;
    rs1 = 5'd7;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || busy !== 32'h0000_0080 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL sb_commit_cycle: got ready=%b busy=%h hazard=%b, required ready=1 busy=00000080 hazard=1",
               issue_ready, busy, hazard);
    end
    cycle();
    checks++;
    if (busy !== 32'd0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: got busy=%h hazard=%b, required busy=0 hazard=0", busy, hazard);
    end
    rs1 = 5'd0;
  endtask

  task automatic test_set_clear();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    cycle();
    issue_valid    = 1'b0;
    req_valid      = 3'b001;
    req_rd[4:0]    = 5'd9;
    req_data[31:0] = 32'h9999_0009;
    exp_q.push_back('{rd: 5'd9, data: 32'h9999_0009});
    cycle();
    req_valid   = 3'b000;
    issue_valid = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL setclr_ready: got %b, required 1", issue_ready);
    end
    cycle();
    issue_valid = 1'b0;
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++;
      $display("FAIL setclr_set_wins: got busy=%h, required 00000200", busy);
    end
    req_valid      = 3'b001;
    req_data[31:0] = 32'h9999_0010;
    exp_q.push_back('{rd: 5'd9, data: 32'h9999_0010});
    cycle();
    req_valid = 3'b000;
    cycle();
    checks++;
    if (busy !== 32'd0) begin
      errors++;
      $display("FAIL setclr_final: got busy=%h, required 0", busy);
    end
  endtask

  task automatic test_rd0();
    req_valid       = 3'b010;
    req_rd          = '0;
    req_data[63:32] = 32'h0000_1234;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL rd0_ready: got %b, required 010", req_ready);
    end
    cycle();
    req_valid = 3'b000;
    checks++;
    if (rf_en !== 1'b0) begin
      errors++;
      $display("FAIL rd0_no_write: got rf_en=%b, required 0", rf_en);
    end
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd0_issue_ready: got %b, required 1", issue_ready);
    end
    cycle();
    issue_valid = 1'b0;
    checks++;
    if (busy !== 32'd0) begin
      errors++;
      $display("FAIL rd0_busy: got %h, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_scoreboard();
    test_set_clear();
    test_rd0();
    cycle();
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
